// File: rtl/seg7_scan_display_pkg.sv
// Purpose : shared glyph constants, scan FSM state type and sizing helpers for 7-seg display blocks.
// Latency : n/a (package only).
// Backpr. : n/a (package only).
// Contents: SEG_OFF (all segments dark incl. dp), GLYPH_0..GLYPH_F as active-low {a,b,c,d,e,f,g},
//           scan_state_t, cnt_max()/idx_width() for counter and index sizing.
package seg7_scan_display_pkg;

  // Active-low {a,b,c,d,e,f,g,dp}: all ones means every segment is off.
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low {a,b,c,d,e,f,g} glyphs. b and d are lower-case so they
  // cannot be confused with 8 and 0.
  localparam logic [6:0] GLYPH_0 = 7'b0000001;
  localparam logic [6:0] GLYPH_1 = 7'b1001111;
  localparam logic [6:0] GLYPH_2 = 7'b0010010;
  localparam logic [6:0] GLYPH_3 = 7'b0000110;
  localparam logic [6:0] GLYPH_4 = 7'b1001100;
  localparam logic [6:0] GLYPH_5 = 7'b0100100;
  localparam logic [6:0] GLYPH_6 = 7'b0100000;
  localparam logic [6:0] GLYPH_7 = 7'b0001111;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0001100;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b1100000;
  localparam logic [6:0] GLYPH_C = 7'b0110001;
  localparam logic [6:0] GLYPH_D = 7'b1000010;
  localparam logic [6:0] GLYPH_E = 7'b0110000;
  localparam logic [6:0] GLYPH_F = 7'b0111000;

  typedef enum logic {
    ST_BLANK   = 1'b0,
    ST_DISPLAY = 1'b1
  } scan_state_t;

  function automatic int cnt_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // A single-digit display still needs a 1-bit index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg7_scan_display_hex_to_seg7.sv
// Purpose : combinational hex nibble to active-low 7-segment glyph decoder.
// Latency : 0 cycles (pure combinational).
// Backpr. : none; output follows input continuously.
// Ports   : nib   in  4  hex value 0..F
//           glyph out 7  active-low {a,b,c,d,e,f,g}
module hex_to_seg7
  import seg7_scan_display_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = GLYPH_8;
    case (nib)
      4'h0: glyph = GLYPH_0;
      4'h1: glyph = GLYPH_1;
      4'h2: glyph = GLYPH_2;
      4'h3: glyph = GLYPH_3;
      4'h4: glyph = GLYPH_4;
      4'h5: glyph = GLYPH_5;
      4'h6: glyph = GLYPH_6;
      4'h7: glyph = GLYPH_7;
      4'h8: glyph = GLYPH_8;
      4'h9: glyph = GLYPH_9;
      4'hA: glyph = GLYPH_A;
      4'hB: glyph = GLYPH_B;
      4'hC: glyph = GLYPH_C;
      4'hD: glyph = GLYPH_D;
      4'hE: glyph = GLYPH_E;
      4'hF: glyph = GLYPH_F;
      default: glyph = GLYPH_8;
    endcase
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Purpose : time-multiplexed common-anode 7-seg driver with frame-aligned double buffer,
//           per-digit enable, decimal points and leading-zero blanking.
// Latency : seg/an registered; a load becomes visible from the first slot after the next frame wrap.
// Backpr. : none; load is always accepted, last load before a wrap wins.
// Ports   : clk, rst (sync, active-high)
//           data[4*NUM_DIGITS]  nibble i = data[4i+3:4i], digit 0 rightmost
//           dp_mask/digit_en[NUM_DIGITS], lz_blank, load  -> pending regs
//           seg[8] {a..g,dp} active-low, an[NUM_DIGITS] one-cold, frame_done 1-cycle pulse
module seg7_scan_display
  import seg7_scan_display_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 100
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_blank,
  input  logic                    load,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CNT_W = $clog2(cnt_max(SCAN_DIV, BLANK_CYCLES) + 1);
  localparam int IDX_W = idx_width(NUM_DIGITS);

  localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
  // With no blank phase the BLANK state only exists for one cycle after reset.
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  // ---------------------------------------------------------------------------
  // Scan FSM / counters
  // ---------------------------------------------------------------------------
  scan_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             wrap;

  // ---------------------------------------------------------------------------
  // Double buffer: pending (written by load) and active (what is scanned out)
  // ---------------------------------------------------------------------------
  logic [4*NUM_DIGITS-1:0] pend_data, act_data, act_data_d;
  logic [NUM_DIGITS-1:0]   pend_dp,   act_dp,   act_dp_d;
  logic [NUM_DIGITS-1:0]   pend_en,   act_en,   act_en_d;
  logic                    pend_lz,   act_lz,   act_lz_d;
  logic                    first_q;
  logic                    copy;

  // ---------------------------------------------------------------------------
  // Digit selection / decode
  // ---------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] lz_sup;
  logic                  zero_run;
  logic [3:0]            nib_sel;
  logic                  en_sel;
  logic                  dp_sel;
  logic                  sup_sel;
  logic                  lit;
  logic [6:0]            glyph;
  logic [7:0]            seg_d;
  logic [NUM_DIGITS-1:0] an_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    wrap    = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if (BLANK_CYCLES == 0 || cnt_q == BLANK_LAST) begin
          state_d = ST_DISPLAY;
          cnt_d   = '0;
        end
      end
      ST_DISPLAY: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d   = '0;
          state_d = (BLANK_CYCLES == 0) ? ST_DISPLAY : ST_BLANK;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            wrap  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  // Active is refreshed from pending on the wrap edge and on the first edge
  // after reset. Pending is sampled before this edge's load, so a load that
  // coincides with the wrap edge waits a full frame.
  always_comb begin
    copy       = wrap | first_q;
    act_data_d = copy ? pend_data : act_data;
    act_dp_d   = copy ? pend_dp   : act_dp;
    act_en_d   = copy ? pend_en   : act_en;
    act_lz_d   = copy ? pend_lz   : act_lz;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      first_q   <= 1'b1;
      pend_data <= '0;
      pend_dp   <= '0;
      pend_en   <= '0;
      pend_lz   <= 1'b0;
      act_data  <= '0;
      act_dp    <= '0;
      act_en    <= '0;
      act_lz    <= 1'b0;
    end else begin
      first_q <= 1'b0;
      if (load) begin
        pend_data <= data;
        pend_dp   <= dp_mask;
        pend_en   <= digit_en;
        pend_lz   <= lz_blank;
      end
      act_data <= act_data_d;
      act_dp   <= act_dp_d;
      act_en   <= act_en_d;
      act_lz   <= act_lz_d;
    end
  end

  // Outputs are computed from the next state/idx/active values so that the
  // registered seg/an change on the same edge as the scan position.
  always_comb begin
    zero_run = 1'b1;
    lz_sup   = '0;
    // Walk from the most significant digit down; a digit is a leading zero
    // while every nibble from it upward is zero. Digit 0 is never blanked.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run  = zero_run & (act_data_d[4*i +: 4] == 4'h0);
      lz_sup[i] = act_lz_d & zero_run & (i != 0);
    end

    nib_sel = '0;
    en_sel  = 1'b0;
    dp_sel  = 1'b0;
    sup_sel = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        nib_sel = act_data_d[4*i +: 4];
        en_sel  = act_en_d[i];
        dp_sel  = act_dp_d[i];
        sup_sel = lz_sup[i];
      end
    end
    lit = (state_d == ST_DISPLAY) & en_sel & ~sup_sel;
  end

  hex_to_seg7 u_hex_to_seg7 (
    .nib   (nib_sel),
    .glyph (glyph)
  );

  always_comb begin
    seg_d = lit ? {glyph, ~dp_sel} : SEG_OFF;
    an_d  = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (lit && idx_d == IDX_W'(i)) begin
        an_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg        <= SEG_OFF;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_d;
      an         <= an_d;
      frame_done <= wrap;
    end
  end

endmodule
